// File: rtl/poke_select_grid.sv
// Tile-grid selection scene: cursor/lock FSM plus a 3-clock pixel pipeline that
// maps VGA counters onto an upscaled sprite strip and draws highlight frames.
module poke_select_grid #(
  parameter int COLS         = 4,
  parameter int ROWS         = 2,
  parameter int H_ORIG       = 40,
  parameter int V_ORIG       = 80,
  parameter int H_PITCH      = 160,
  parameter int V_PITCH      = 160,
  parameter int TILE_LEN     = 120,
  parameter int RESIZE_SHIFT = 1,
  parameter int IMG_W        = 480,
  parameter int BORDER       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_confirm,
  input  logic        btn_cancel,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [11:0] poke_mem_vga_data,
  output logic [16:0] pixel_addr,
  output logic [11:0] vga_data,
  output logic [7:0]  cursor_id,
  output logic [7:0]  selected_id,
  output logic        select_valid
);

  localparam int         SPR_LEN = TILE_LEN >> RESIZE_SHIFT;
  localparam logic [2:0] C_MAX   = 3'(COLS - 1);
  localparam logic [1:0] R_MAX   = 2'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, BROWSE, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [2:0] cur_c, col_nxt;
  logic [1:0] cur_r, row_nxt;
  logic       do_lock, do_unlock;

  function automatic logic [31:0] col_org(input int c);
    return 32'(H_ORIG + c * H_PITCH);
  endfunction

  function automatic logic [31:0] row_org(input int r);
    return 32'(V_ORIG + r * V_PITCH);
  endfunction

  function automatic logic in_border(input logic [31:0] off);
    return (off < 32'(BORDER)) || (off >= 32'(TILE_LEN - BORDER));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = BROWSE;
        BROWSE:  if (btn_confirm) state_nxt = LOCKED;
        LOCKED:  if (btn_cancel) state_nxt = BROWSE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Confirm suppresses any move in the same clock; moves resolve left > right > up > down.
  always_comb begin
    do_lock   = enable && (state == BROWSE) && btn_confirm;
    do_unlock = (state == LOCKED) && (!enable || btn_cancel);
    col_nxt   = cur_c;
    row_nxt   = cur_r;
    if (enable && (state == BROWSE) && !btn_confirm) begin
      if (btn_left)       col_nxt = (cur_c == 3'd0)  ? C_MAX : cur_c - 3'd1;
      else if (btn_right) col_nxt = (cur_c == C_MAX) ? 3'd0  : cur_c + 3'd1;
      else if (btn_up)    row_nxt = (cur_r == 2'd0)  ? R_MAX : cur_r - 2'd1;
      else if (btn_down)  row_nxt = (cur_r == R_MAX) ? 2'd0  : cur_r + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_c        <= 3'd0;
      cur_r        <= 2'd0;
      cursor_id    <= 8'd1;
      selected_id  <= 8'd0;
      select_valid <= 1'b0;
    end else begin
      cur_c     <= col_nxt;
      cur_r     <= row_nxt;
      cursor_id <= {6'd0, row_nxt} * 8'(COLS) + {5'd0, col_nxt} + 8'd1;
      if (do_lock) begin
        selected_id  <= cursor_id;
        select_valid <= 1'b1;
      end else if (do_unlock) begin
        selected_id  <= 8'd0;
        select_valid <= 1'b0;
      end
    end
  end

  // Stage p0: combinational tile hit, tile index, border flag and sprite address.
  logic [31:0] h_ext, v_ext, h_off_p0, v_off_p0;
  logic        hit_h, hit_v, vld_p0, border_p0;
  logic [2:0]  col_p0;
  logic [1:0]  row_p0;
  logic [4:0]  tile_p0;
  logic [16:0] addr_p0;

  always_comb begin
    h_ext    = {22'd0, h_cnt};
    v_ext    = {22'd0, v_cnt};
    hit_h    = 1'b0;
    hit_v    = 1'b0;
    col_p0   = 3'd0;
    row_p0   = 2'd0;
    h_off_p0 = 32'd0;
    v_off_p0 = 32'd0;
    for (int c = 0; c < COLS; c++) begin
      if (h_ext >= col_org(c) && h_ext < col_org(c) + 32'(TILE_LEN)) begin
        hit_h    = 1'b1;
        col_p0   = 3'(c);
        h_off_p0 = h_ext - col_org(c);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (v_ext >= row_org(r) && v_ext < row_org(r) + 32'(TILE_LEN)) begin
        hit_v    = 1'b1;
        row_p0   = 2'(r);
        v_off_p0 = v_ext - row_org(r);
      end
    end
    vld_p0    = hit_h && hit_v && (h_cnt < 10'd640) && (v_cnt < 10'd480);
    tile_p0   = {3'd0, row_p0} * 5'(COLS) + {2'd0, col_p0};
    border_p0 = in_border(h_off_p0) || in_border(v_off_p0);
    addr_p0   = 17'((h_off_p0 >> RESIZE_SHIFT) + {27'd0, tile_p0} * 32'(SPR_LEN)
                    + 32'(IMG_W) * (v_off_p0 >> RESIZE_SHIFT));
  end

  // Stage p1: registered address goes to sprite memory; flags start their delay.
  logic       vld_p1, border_p1, vld_p2, border_p2;
  logic [4:0] tile_p1, tile_p2;
  logic [7:0] tile_id_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr <= 17'd0;
      vld_p1     <= 1'b0;
      tile_p1    <= 5'd0;
      border_p1  <= 1'b0;
    end else begin
      pixel_addr <= vld_p0 ? addr_p0 : 17'd0;
      vld_p1     <= vld_p0;
      tile_p1    <= tile_p0;
      border_p1  <= border_p0;
    end
  end

  // Stage p2: flags wait for memory data, which arrives one clock after the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      tile_p2   <= 5'd0;
      border_p2 <= 1'b0;
    end else begin
      vld_p2    <= vld_p1;
      tile_p2   <= tile_p1;
      border_p2 <= border_p1;
    end
  end

  assign tile_id_p2 = {3'd0, tile_p2} + 8'd1;

  // Stage p3: final pixel colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_data <= 12'h000;
    end else if (!vld_p2 || state == IDLE) begin
      vga_data <= 12'h000;
    end else if (border_p2 && state == BROWSE && tile_id_p2 == cursor_id) begin
      vga_data <= 12'hF00;
    end else if (border_p2 && state == LOCKED && tile_id_p2 == selected_id) begin
      vga_data <= 12'h0F0;
    end else begin
      vga_data <= poke_mem_vga_data;
    end
  end

endmodule

// File: tb/tb_poke_select_grid.sv
// Bench for poke_select_grid: directed cursor/lock scenarios plus a queued
// scoreboard for the 3-clock pixel pipeline against a division-based model.
module tb_poke_select_grid;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        btn_left, btn_right, btn_up, btn_down, btn_confirm, btn_cancel;
  logic [9:0]  h_cnt, v_cnt;
  logic [11:0] poke_mem_vga_data;
  logic [16:0] pixel_addr;
  logic [11:0] vga_data;
  logic [7:0]  cursor_id, selected_id;
  logic        select_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        hit;
    int          k;
    logic        border;
    logic [16:0] addr;
    logic [11:0] vga;
  } pix_t;

  // {left, right, up, down, confirm, cancel} and the cursor_id expected after each
  localparam logic [5:0] MV_BTN [12] = '{6'b100000, 6'b000100, 6'b010000, 6'b001000,
                                         6'b001000, 6'b000100, 6'b111000, 6'b011100,
                                         6'b001100, 6'b000100, 6'b010000, 6'b000001};
  localparam int         MV_ID  [12] = '{4, 8, 5, 1, 5, 1, 4, 1, 5, 1, 2, 2};
  localparam int         DIR_H  [6]  = '{360, 200, 479, 400, 319, 43};
  localparam int         DIR_V  [6]  = '{80, 80, 199, 120, 279, 83};

  poke_select_grid dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .poke_mem_vga_data(poke_mem_vga_data),
    .pixel_addr(pixel_addr), .vga_data(vga_data), .cursor_id(cursor_id),
    .selected_id(selected_id), .select_valid(select_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [5:0] b);
    {btn_left, btn_right, btn_up, btn_down, btn_confirm, btn_cancel} = b;
    step();
    {btn_left, btn_right, btn_up, btn_down, btn_confirm, btn_cancel} = 6'b0;
  endtask

  function automatic pix_t model(input int h, input int v);
    pix_t p;
    int dh, dv, c, r, oh, ov;
    p.hit = 1'b0; p.k = 0; p.border = 1'b0; p.addr = 17'd0; p.vga = 12'h000;
    if (h >= 640 || v >= 480 || h < 40 || v < 80) return p;
    dh = h - 40;  c = dh / 160; oh = dh % 160;
    dv = v - 80;  r = dv / 160; ov = dv % 160;
    if (c >= 4 || r >= 2 || oh >= 120 || ov >= 120) return p;
    p.hit    = 1'b1;
    p.k      = r * 4 + c;
    p.border = (oh < 4) || (oh >= 116) || (ov < 4) || (ov >= 116);
    p.addr   = 17'((oh >> 1) + p.k * 60 + 480 * (ov >> 1));
    return p;
  endfunction

  function automatic logic [11:0] exp_vga(input pix_t p, input logic [11:0] mem,
                                          input int mode, input int cur, input int sel);
    if (!p.hit || mode == 0) return 12'h000;
    if (p.border && mode == 1 && p.k + 1 == cur) return 12'hF00;
    if (p.border && mode == 2 && p.k + 1 == sel) return 12'h0F0;
    return mem;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    {btn_left, btn_right, btn_up, btn_down, btn_confirm, btn_cancel} = 6'b0;
    h_cnt = 10'd100; v_cnt = 10'd150; poke_mem_vga_data = 12'hABC;
    step(); step(); step();
    total++; if (cursor_id !== 8'd1) begin bad++; $display("FAIL reset_cursor got=%0d want=1", cursor_id); end
    total++; if (selected_id !== 8'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", selected_id); end
    total++; if (select_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", select_valid); end
    total++; if (pixel_addr !== 17'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", pixel_addr); end
    total++; if (vga_data !== 12'h000) begin bad++; $display("FAIL reset_vga got=%h want=000", vga_data); end
    rst_n = 1'b1;
    h_cnt = 10'd700;
    step();
  endtask

  task automatic test_moves();
    enable = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      pulse(MV_BTN[i]);
      total++;
      if (cursor_id !== 8'(MV_ID[i])) begin
        bad++; $display("FAIL move_%0d got=%0d want=%0d", i, cursor_id, MV_ID[i]);
      end
    end
    total++; if (select_valid !== 1'b0) begin bad++; $display("FAIL cancel_in_browse got=%b want=0", select_valid); end
  endtask

  task automatic test_confirm_cancel();
    pulse(6'b010010);
    total++; if (selected_id !== 8'd2) begin bad++; $display("FAIL lock_sel got=%0d want=2", selected_id); end
    total++; if (select_valid !== 1'b1) begin bad++; $display("FAIL lock_valid got=%b want=1", select_valid); end
    total++; if (cursor_id !== 8'd2) begin bad++; $display("FAIL lock_cursor got=%0d want=2", cursor_id); end
    pulse(6'b100000);
    total++; if (cursor_id !== 8'd2) begin bad++; $display("FAIL locked_move got=%0d want=2", cursor_id); end
    pulse(6'b000010);
    total++; if (selected_id !== 8'd2) begin bad++; $display("FAIL locked_confirm got=%0d want=2", selected_id); end
    pulse(6'b000001);
    total++; if (selected_id !== 8'd0) begin bad++; $display("FAIL cancel_sel got=%0d want=0", selected_id); end
    total++; if (select_valid !== 1'b0) begin bad++; $display("FAIL cancel_valid got=%b want=0", select_valid); end
    pulse(6'b010000);
    total++; if (cursor_id !== 8'd3) begin bad++; $display("FAIL browse_resume got=%0d want=3", cursor_id); end
  endtask

  task automatic test_enable_low();
    pulse(6'b000010);
    total++; if (selected_id !== 8'd3) begin bad++; $display("FAIL lock3_sel got=%0d want=3", selected_id); end
    enable = 1'b0;
    step();
    total++; if (selected_id !== 8'd0) begin bad++; $display("FAIL dis_sel got=%0d want=0", selected_id); end
    total++; if (select_valid !== 1'b0) begin bad++; $display("FAIL dis_valid got=%b want=0", select_valid); end
    pulse(6'b100000);
    total++; if (cursor_id !== 8'd3) begin bad++; $display("FAIL idle_move got=%0d want=3", cursor_id); end
    enable = 1'b1;
    step();
    pulse(6'b100000);
    total++; if (cursor_id !== 8'd2) begin bad++; $display("FAIL reenable_move got=%0d want=2", cursor_id); end
  endtask

  task automatic pixel_point(input int h, input int v, input logic [16:0] want_addr,
                             input logic [11:0] want_vga);
    h_cnt = 10'(h); v_cnt = 10'(v); poke_mem_vga_data = 12'h000;
    step();
    h_cnt = 10'd700;
    total++;
    if (pixel_addr !== want_addr) begin
      bad++; $display("FAIL addr_%0d_%0d got=%0d want=%0d", h, v, pixel_addr, want_addr);
    end
    step();
    poke_mem_vga_data = 12'hABC;
    step();
    total++;
    if (vga_data !== want_vga) begin
      bad++; $display("FAIL vga_%0d_%0d got=%h want=%h", h, v, vga_data, want_vga);
    end
  endtask

  task automatic test_pixel_points();
    pixel_point(200, 80, 17'd60, 12'hF00);
    pixel_point(100, 150, 17'd16830, 12'hABC);
    pixel_point(170, 100, 17'd0, 12'h000);
    pixel_point(700, 100, 17'd0, 12'h000);
    pulse(6'b010000);
    pixel_point(200, 80, 17'd60, 12'hABC);
  endtask

  task automatic test_stream(input int mode, input int cur, input int sel, input int n);
    pix_t addr_q[$];
    pix_t data_q[$];
    pix_t vga_q[$];
    pix_t e;
    int   h, v;
    for (int i = 0; i < n + 3; i++) begin
      if (vga_q.size() > 0) begin
        e = vga_q.pop_front();
        total++;
        if (vga_data !== e.vga) begin
          bad++; $display("FAIL stream_vga m%0d k=%0d got=%h want=%h", mode, e.k, vga_data, e.vga);
        end
      end
      if (data_q.size() > 0) begin
        e = data_q.pop_front();
        poke_mem_vga_data = 12'($urandom);
        e.vga = exp_vga(e, poke_mem_vga_data, mode, cur, sel);
        vga_q.push_back(e);
      end
      if (addr_q.size() > 0) begin
        e = addr_q.pop_front();
        total++;
        if (pixel_addr !== e.addr) begin
          bad++; $display("FAIL stream_addr m%0d got=%0d want=%0d", mode, pixel_addr, e.addr);
        end
        data_q.push_back(e);
      end
      if (i < n) begin
        if (i < 6) begin
          h = DIR_H[i]; v = DIR_V[i];
        end else begin
          h = int'($urandom_range(0, 799));
          v = int'($urandom_range(0, 524));
        end
        h_cnt = 10'(h); v_cnt = 10'(v);
        addr_q.push_back(model(h, v));
      end else begin
        h_cnt = 10'd700;
      end
      step();
    end
  endtask

  task automatic test_reset_locked();
    pulse(6'b000010);
    h_cnt = 10'd100; v_cnt = 10'd150; poke_mem_vga_data = 12'hABC;
    step(); step(); step(); step();
    total++; if (vga_data !== 12'hABC) begin bad++; $display("FAIL prereset_vga got=%h want=abc", vga_data); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (cursor_id !== 8'd1) begin bad++; $display("FAIL rst_cursor got=%0d want=1", cursor_id); end
    total++; if (selected_id !== 8'd0) begin bad++; $display("FAIL rst_sel got=%0d want=0", selected_id); end
    total++; if (select_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", select_valid); end
    total++; if (pixel_addr !== 17'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", pixel_addr); end
    total++; if (vga_data !== 12'h000) begin bad++; $display("FAIL rst_vga got=%h want=000", vga_data); end
    step();
    total++; if (vga_data !== 12'h000) begin bad++; $display("FAIL rst_hold_vga got=%h want=000", vga_data); end
    rst_n = 1'b1;
    step();
    pulse(6'b010000);
    total++; if (cursor_id !== 8'd2) begin bad++; $display("FAIL post_rst_move got=%0d want=2", cursor_id); end
  endtask

  initial begin
    test_reset();
    test_moves();
    test_confirm_cancel();
    test_enable_low();
    test_pixel_points();
    test_stream(1, 3, 0, 40);
    pulse(6'b000010);
    test_stream(2, 3, 3, 40);
    enable = 1'b0;
    step();
    test_stream(0, 3, 0, 10);
    enable = 1'b1;
    step();
    test_reset_locked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
